// File: rtl/chan_512_ctrl_pkg.sv
// Shared definitions for the chan_512 control-register consumer:
// field map of the register word, sweep FSM states and a field decoder.
package chan_512_ctrl_pkg;

  localparam int REG_W      = 32;
  localparam int NCH        = 512;
  localparam int STAB_CNT_W = 4;

  localparam int CH_SEL_LSB = 0;
  localparam int CH_SEL_W   = 9;
  localparam int LOAD_BIT   = 9;
  localparam int START_BIT  = 10;
  localparam int ABORT_BIT  = 11;
  localparam int END_LSB    = 12;
  localparam int END_W      = 9;
  localparam int DWELL_LSB  = 21;
  localparam int DWELL_W    = 7;
  localparam int RSVD_W     = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_LOAD = 2'd1,
    EMIT      = 2'd2,
    DWELL     = 2'd3
  } sweep_state_e;

  typedef struct packed {
    logic [RSVD_W-1:0]   rsvd;
    logic [DWELL_W-1:0]  dwell;
    logic [END_W-1:0]    sweep_end;
    logic                abort;
    logic                start;
    logic                load;
    logic [CH_SEL_W-1:0] ch_sel;
  } ctrl_fields_t;

  function automatic ctrl_fields_t decode_ctrl(input logic [REG_W-1:0] w);
    ctrl_fields_t f;
    f.ch_sel    = w[CH_SEL_LSB +: CH_SEL_W];
    f.load      = w[LOAD_BIT];
    f.start     = w[START_BIT];
    f.abort     = w[ABORT_BIT];
    f.sweep_end = w[END_LSB +: END_W];
    f.dwell     = w[DWELL_LSB +: DWELL_W];
    f.rsvd      = w[REG_W-1 -: RSVD_W];
    return f;
  endfunction

endpackage

// File: rtl/chan_512_ctrl_decode_if.sv
// Register-in / channel-out bundle between the control register stage,
// the decoder and the 512-channel datapath.
interface chan_512_ctrl_decode_if #(
  parameter int NCH_BITS = chan_512_ctrl_pkg::CH_SEL_W
);
  logic [31:0]         user_data_out;
  logic                ch_ready;
  logic [31:0]         reg_shadow;
  logic                cfg_update;
  logic [NCH_BITS-1:0] ch_out;
  logic                ch_valid;
  logic                sweep_busy;
  logic                sweep_done;

  modport master (
    output user_data_out,
    output ch_ready,
    input  reg_shadow,
    input  cfg_update,
    input  ch_out,
    input  ch_valid,
    input  sweep_busy,
    input  sweep_done
  );

  modport slave (
    input  user_data_out,
    input  ch_ready,
    output reg_shadow,
    output cfg_update,
    output ch_out,
    output ch_valid,
    output sweep_busy,
    output sweep_done
  );
endinterface

// File: rtl/chan_512_reg_stabilizer.sv
// Accepts a software register word only after it has been seen unchanged for
// STABLE_CYCLES consecutive samples; keeps it as a shadow with an update pulse.
module chan_512_reg_stabilizer
  import chan_512_ctrl_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int W             = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] shadow_o,
  output logic         update_o
);

  localparam logic [STAB_CNT_W-1:0] ACCEPT_CNT = STAB_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_CNT_W-1:0] CNT_MAX    = '1;

  logic [W-1:0]          raw_q;
  logic [W-1:0]          prev_q;
  logic [W-1:0]          shadow_q;
  logic [STAB_CNT_W-1:0] cnt_q;
  logic [STAB_CNT_W-1:0] cnt_d;
  logic                  upd_q;
  logic                  accept;

  // Acceptance looks at the next count so the shadow loads on the same edge
  // the run length is reached, giving STABLE_CYCLES+1 cycles of latency.
  always_comb begin
    cnt_d = '0;
    if (raw_q == prev_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
    accept = (cnt_d == ACCEPT_CNT) && (raw_q != shadow_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raw_q    <= '0;
      prev_q   <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
    end else begin
      raw_q  <= data_i;
      prev_q <= raw_q;
      cnt_q  <= cnt_d;
      upd_q  <= accept;
      if (accept) begin
        shadow_q <= raw_q;
      end
    end
  end

  assign shadow_o = shadow_q;
  assign update_o = upd_q;

endmodule

// File: rtl/chan_512_ctrl_decode.sv
// Decodes the stabilised chan_512 control word into load/sweep commands and
// streams channel indices to the datapath over a valid/ready handshake.
module chan_512_ctrl_decode
  import chan_512_ctrl_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NCH_BITS      = 9
) (
  input  logic                  user_clk,
  input  logic                  user_rst_n,
  chan_512_ctrl_decode_if.slave bus
);

  logic [REG_W-1:0]    shadow;
  logic                cfg_upd;
  ctrl_fields_t        fields;
  logic                unused_rsvd;

  logic [1:0]          cmd_now;
  logic [1:0]          cmd_dly_q;
  logic [1:0]          cmd_pulse;
  logic                load_p;
  logic                start_p;

  sweep_state_e        state_q;
  logic [NCH_BITS-1:0] cur_q;
  logic [NCH_BITS-1:0] end_q;
  logic [NCH_BITS-1:0] cur_inc;
  logic [DWELL_W-1:0]  dw_q;
  logic [DWELL_W-1:0]  dcnt_q;
  logic [NCH_BITS-1:0] ch_out_q;
  logic                ch_valid_q;
  logic                busy_q;
  logic                done_q;

  chan_512_reg_stabilizer #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .W             (REG_W)
  ) u_stab (
    .clk_i    (user_clk),
    .rst_ni   (user_rst_n),
    .data_i   (bus.user_data_out),
    .shadow_o (shadow),
    .update_o (cfg_upd)
  );

  assign fields      = decode_ctrl(shadow);
  assign unused_rsvd = ^fields.rsvd;

  // Command bits are edge-triggered: bit 0 = load, bit 1 = start.
  assign cmd_now = {fields.start, fields.load};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cmd_edge
      assign cmd_pulse[gi] = cmd_now[gi] & ~cmd_dly_q[gi];
    end
  endgenerate

  assign load_p  = cmd_pulse[0];
  assign start_p = cmd_pulse[1];
  assign cur_inc = cur_q + 1'b1;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      cmd_dly_q <= '0;
    end else begin
      cmd_dly_q <= cmd_now;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      end_q      <= '0;
      dw_q       <= '0;
      dcnt_q     <= '0;
      ch_out_q   <= '0;
      ch_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != IDLE) && fields.abort) begin
        // A handshake completing on this edge is already delivered downstream.
        state_q    <= IDLE;
        ch_valid_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // Start takes priority; a coincident load is dropped even if
            // the start itself is blocked by abort.
            if (start_p) begin
              if (!fields.abort) begin
                cur_q      <= NCH_BITS'(fields.ch_sel);
                end_q      <= NCH_BITS'(fields.sweep_end);
                dw_q       <= fields.dwell;
                ch_out_q   <= NCH_BITS'(fields.ch_sel);
                ch_valid_q <= 1'b1;
                busy_q     <= 1'b1;
                state_q    <= EMIT;
              end
            end else if (load_p) begin
              ch_out_q   <= NCH_BITS'(fields.ch_sel);
              ch_valid_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= HOLD_LOAD;
            end
          end

          HOLD_LOAD: begin
            if (bus.ch_ready) begin
              ch_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end
          end

          EMIT: begin
            if (bus.ch_ready) begin
              if (cur_q == end_q) begin
                ch_valid_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                state_q    <= IDLE;
              end else if (dw_q == '0) begin
                cur_q    <= cur_inc;
                ch_out_q <= cur_inc;
              end else begin
                ch_valid_q <= 1'b0;
                dcnt_q     <= dw_q;
                state_q    <= DWELL;
              end
            end
          end

          DWELL: begin
            if (dcnt_q == DWELL_W'(1)) begin
              cur_q      <= cur_inc;
              ch_out_q   <= cur_inc;
              ch_valid_q <= 1'b1;
              state_q    <= EMIT;
            end else begin
              dcnt_q <= dcnt_q - 1'b1;
            end
          end

          default: begin
            state_q    <= IDLE;
            ch_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.reg_shadow = shadow;
  assign bus.cfg_update = cfg_upd;
  assign bus.ch_out     = ch_out_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.sweep_busy = busy_q;
  assign bus.sweep_done = done_q;

endmodule
